led_pwm_ctrl: RTL
=================

# led_pwm_ctrl

Register-mapped, parametrised LED PWM controller driving NCH channels (default 3, feeding the RGB driver PWM inputs). It replaces the fixed 3-bit LED state counter with per-channel duty, static/blink/breathe modes and a programmable prescaler. It sits on the SPI slave register bus (we/re/addr/wdat/rdat) alongside the other writeable registers, in the system clock domain.

## Interface
- NCH, 3: channel count, 1..8
- PWM_W, 8: duty/PWM counter width, 4..12
- PRE_W, 16: prescaler width
- BASE, 7'h10: first register address; block decodes BASE..BASE+2+2*NCH-1
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  single-cycle write strobe
- re  in  1  single-cycle read strobe (no side effects)
- addr  in  7  word address
- wdat  in  32  write data
- rdat  out  32  combinational read data; 0 when addr not decoded
- hit  out  1  combinational, high when addr is in this block's range
- pwm  out  NCH  registered PWM outputs, bit i = channel i
- frame  out  1  registered one-cycle pulse at each PWM frame end

## Operation
- Registers (offsets from BASE; wdat upper bits beyond field width ignored):
  - +0 CTRL: bit0 global enable. Read: {8'(NCH), 8'(PWM_W), 15'b0, enable}.
  - +1 PRESC: PRE_W bits. One PWM tick every PRESC+1 clocks.
  - +2+2i DUTY_i: PWM_W bits, target duty of channel i.
  - +3+2i MODE_i: bits[1:0] mode (0 static, 1 blink, 2 breathe, 3 = static); bits[15:8] RATE.
- Prescaler counter pc: while enabled, pc==PRESC -> tick, pc<=0; else pc+1. Disabled: pc, PWM counter, all channel state held at 0; pwm=0.
- PWM counter cnt (PWM_W bits): +1 per tick, wraps all-ones -> 0. Frame end = tick with cnt all-ones.
- Per channel, at each frame end: working level lev_i updated, then pwm_i = (cnt < lev_i) on every clock. lev_i=0 -> always low; max -> high (2^PWM_W-1) of 2^PWM_W slots.
- Static: lev_i <= DUTY_i at frame end (DUTY writes never take effect mid-frame).
- Blink: 8-bit frame counter fc_i; fc_i==RATE -> fc_i<=0, phase_i toggles; lev_i <= phase_i ? DUTY_i : 0 (using post-toggle phase). Half period = RATE+1 frames.
- Breathe: fc_i as above; on fc_i==RATE step lev_i by 1 toward DUTY_i (dir up) or 0 (dir down); reverse dir on reaching endpoint. DUTY_i lowered below lev_i while up -> lev_i <= DUTY_i, dir down.
- Write to MODE_i: fc_i, phase_i, lev_i cleared to 0, dir set up; takes effect same clock as write.
- Writing CTRL enable 1->0: immediate stop, pwm=0 next clock. 0->1: pc, cnt start from 0.
- Simultaneous we to MODE_i and frame end: write wins (state cleared).

## Timing
- Reset (reset_n low, async): CTRL=0, PRESC=0, all DUTY/MODE=0, pc=cnt=0, lev/fc/phase=0, dir up; pwm=0, frame=0.
- Register write visible on rdat the clock after we.
- pwm_i changes 1 clock after cnt changes (registered compare); frame pulses 1 clock after frame-end tick.
- Frame period = (PRESC+1)*2^PWM_W clocks. PRESC=0: tick every clock.
- Reset asserted mid-frame: outputs low immediately (async), all state as above.

## Test plan
- Reset: reset_n low mid-operation -> pwm=0, frame=0 asynchronously; read BASE+0 returns 0x03080000 with defaults.
- Static: enable, PRESC=0, DUTY_0=64 -> pwm[0] high exactly 64 of every 256 clocks, first full frame after next frame end; DUTY_0=0 -> never high; 255 -> 255/256.
- Mid-frame duty write: DUTY_1 100->10 at cnt=50 -> current frame keeps 100-clock high; next frame 10.
- Blink: DUTY_2=255, mode 1, RATE=1, PRESC=0 -> pwm[2] alternates 2 frames on (255/256) / 2 frames off; frame pulse every 256 clocks.
- Breathe: PWM_W=4 build, DUTY=3, RATE=0 -> lev sequence per frame 1,2,3,2,1,0,1...; DUTY lowered to 1 while lev=3 climbing -> lev=1, descending.
- Bus: unmapped addr -> rdat=0, hit=0; MODE write coincident with frame end -> lev=0, fc=0; disable mid-frame -> pwm=0 next clock, cnt restarts at 0 on re-enable.

Source files
------------

// File: rtl/led_pwm_ctrl.sv
// LED PWM controller: per-channel duty with static, blink and breathe modes on a register bus.
// pwm and frame are registered one clock behind the PWM counter; reads are combinational.
module led_pwm_ctrl #(
    parameter int         NCH   = 3,
    parameter int         PWM_W = 8,
    parameter int         PRE_W = 16,
    parameter logic [6:0] BASE  = 7'h10
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           we,
    input  logic           re,
    input  logic [6:0]     addr,
    input  logic [31:0]    wdat,
    output logic [31:0]    rdat,
    output logic           hit,
    output logic [NCH-1:0] pwm,
    output logic           frame
);
    localparam logic [6:0]       NREG = 7'(2 + 2 * NCH);
    localparam logic [PWM_W-1:0] ONE  = PWM_W'(1);

    logic                 en;
    logic [PRE_W-1:0]     presc;
    logic [PWM_W-1:0]     duty [NCH];
    logic [1:0]           mode [NCH];
    logic [7:0]           rate [NCH];

    logic [PRE_W-1:0]     pc;
    logic [PWM_W-1:0]     cnt;
    logic [PWM_W-1:0]     lev  [NCH];
    logic [7:0]           fc   [NCH];
    logic [NCH-1:0]       phase;
    logic [NCH-1:0]       dir_dn;

    logic [6:0]           off;
    logic                 wr_ctrl, wr_presc, en_nxt, tick, frame_end;
    logic [NCH-1:0]       wr_duty, wr_mode, step;
    logic                 unused;

    assign off       = addr - BASE;
    assign hit       = (addr >= BASE) && (off < NREG);
    assign wr_ctrl   = we && hit && (off == 7'd0);
    assign wr_presc  = we && hit && (off == 7'd1);
    assign en_nxt    = wr_ctrl ? wdat[0] : en;
    assign tick      = en && (pc == presc);
    assign frame_end = tick && (cnt == '1);
    assign unused    = ^{re, wdat};

    always_comb begin
        wr_duty = '0;
        wr_mode = '0;
        step    = '0;
        for (int i = 0; i < NCH; i++) begin
            wr_duty[i] = we && hit && (off == 7'(2 + 2 * i));
            wr_mode[i] = we && hit && (off == 7'(3 + 2 * i));
            step[i]    = (fc[i] == rate[i]);
        end
    end

    always_comb begin
        rdat = '0;
        if (hit) begin
            if (off == 7'd0) rdat = {8'(NCH), 8'(PWM_W), 15'b0, en};
            if (off == 7'd1) rdat = 32'(presc);
            for (int i = 0; i < NCH; i++) begin
                if (off == 7'(2 + 2 * i)) rdat = 32'(duty[i]);
                if (off == 7'(3 + 2 * i)) rdat = {16'b0, rate[i], 6'b0, mode[i]};
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en    <= 1'b0;
            presc <= '0;
            for (int i = 0; i < NCH; i++) begin
                duty[i] <= '0;
                mode[i] <= '0;
                rate[i] <= '0;
            end
        end else begin
            en <= en_nxt;
            if (wr_presc) presc <= wdat[PRE_W-1:0];
            for (int i = 0; i < NCH; i++) begin
                if (wr_duty[i]) duty[i] <= wdat[PWM_W-1:0];
                if (wr_mode[i]) begin
                    mode[i] <= wdat[1:0];
                    rate[i] <= wdat[15:8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= '0;
            cnt    <= '0;
            pwm    <= '0;
            frame  <= 1'b0;
            phase  <= '0;
            dir_dn <= '0;
            for (int i = 0; i < NCH; i++) begin
                lev[i] <= '0;
                fc[i]  <= '0;
            end
        end else begin
            // Disabling acts on the write edge itself so pwm is low the next clock.
            if (!en_nxt) begin
                pc    <= '0;
                cnt   <= '0;
                pwm   <= '0;
                frame <= 1'b0;
            end else begin
                frame <= frame_end;
                if (en) begin
                    pc <= tick ? '0 : pc + PRE_W'(1);
                    if (tick) cnt <= cnt + ONE;
                end
                for (int i = 0; i < NCH; i++) pwm[i] <= en && (cnt < lev[i]);
            end

            for (int i = 0; i < NCH; i++) begin
                if (!en_nxt || wr_mode[i]) begin
                    lev[i]    <= '0;
                    fc[i]     <= '0;
                    phase[i]  <= 1'b0;
                    dir_dn[i] <= 1'b0;
                end else if (frame_end) begin
                    fc[i] <= step[i] ? 8'd0 : fc[i] + 8'd1;
                    case (mode[i])
                        2'd1: begin
                            phase[i] <= phase[i] ^ step[i];
                            lev[i]   <= (phase[i] ^ step[i]) ? duty[i] : '0;
                        end
                        2'd2: if (step[i]) begin
                            if (!dir_dn[i]) begin
                                // Also catches a duty lowered beneath the current level.
                                if (lev[i] >= duty[i]) begin
                                    lev[i]    <= duty[i];
                                    dir_dn[i] <= 1'b1;
                                end else begin
                                    lev[i] <= lev[i] + ONE;
                                    if (lev[i] + ONE == duty[i]) dir_dn[i] <= 1'b1;
                                end
                            end else begin
                                if (lev[i] != '0) lev[i] <= lev[i] - ONE;
                                if (lev[i] <= ONE) dir_dn[i] <= 1'b0;
                            end
                        end
                        default: lev[i] <= duty[i];
                    endcase
                end
            end
        end
    end
endmodule
